// File: rtl/seq_control_unit_if.sv
// rtl/seq_control_unit_if.sv - datapath-side bundle of the multicycle sequencer
interface seq_control_unit_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             zero;
  logic             run;
  logic             step;
  logic             s_inc;
  logic             s_inm;
  logic             we;
  logic             wez;
  logic [2:0]       ALUOp;
  logic             pc_en;
  logic             ir_en;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output opcode, zero, run, step,
    input  s_inc, s_inm, we, wez, ALUOp, pc_en, ir_en, busy, halted, illegal, instr_cnt
  );

  modport slave (
    input  opcode, zero, run, step,
    output s_inc, s_inm, we, wez, ALUOp, pc_en, ir_en, busy, halted, illegal, instr_cnt
  );
endinterface

// File: rtl/seq_control_unit.sv
// rtl/seq_control_unit.sv - multicycle fetch/decode/exec sequencer with run/step, HALT and retire counter
// Optional SEQ_ILLEGAL_TRAP_EN: reserved opcodes trap into HALT and raise a sticky illegal flag.
module seq_control_unit #(
  parameter int         CNT_W    = 16,
  parameter logic [5:0] HALT_OPC = 6'b111111
) (
  input logic              clk,
  input logic              reset,
  seq_control_unit_if.slave bus
);
  localparam logic [5:0] OP_J   = 6'b100000;
  localparam logic [5:0] OP_JZ  = 6'b100001;
  localparam logic [5:0] OP_JNZ = 6'b100010;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic             step_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             trap;
  logic             s_inc, s_inm, we, wez, pc_en, ir_en, busy, halted;
  logic [2:0]       alu_op;

  function automatic logic is_jump(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JZ) || (op == OP_JNZ);
  endfunction

`ifdef SEQ_ILLEGAL_TRAP_EN
  function automatic logic is_reserved(input logic [5:0] op);
    return op[5] && !is_jump(op) && (op != HALT_OPC);
  endfunction
`endif

  logic taken;
  assign taken = (op_q == OP_J) || ((op_q == OP_JZ) && bus.zero) ||
                 ((op_q == OP_JNZ) && !bus.zero);

  always_comb begin
    state_d = state_q;
    s_inc   = 1'b0;
    s_inm   = 1'b0;
    we      = 1'b0;
    wez     = 1'b0;
    alu_op  = 3'b000;
    pc_en   = 1'b0;
    ir_en   = 1'b0;
    halted  = 1'b0;
    retire  = 1'b0;
    trap    = 1'b0;
    busy    = (state_q != IDLE) && (state_q != HALT);
    case (state_q)
      IDLE: begin
        if (bus.run || step_q) state_d = FETCH;
      end
      FETCH: begin
        ir_en   = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (bus.opcode == HALT_OPC) begin
          state_d = HALT;
`ifdef SEQ_ILLEGAL_TRAP_EN
        end else if (is_reserved(bus.opcode)) begin
          state_d = HALT;
          trap    = 1'b1;
`endif
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!op_q[5]) begin
          alu_op  = op_q[2:0];
          s_inm   = op_q[4];
          state_d = WB;
        end else begin
          // Jumps and reserved opcodes both retire here; only a taken jump selects the target
          pc_en   = 1'b1;
          s_inc   = !(is_jump(op_q) && taken);
          retire  = 1'b1;
          state_d = bus.run ? FETCH : IDLE;
        end
      end
      WB: begin
        alu_op  = op_q[2:0];
        s_inm   = op_q[4];
        we      = 1'b1;
        wez     = 1'b1;
        pc_en   = 1'b1;
        s_inc   = 1'b1;
        retire  = 1'b1;
        state_d = bus.run ? FETCH : IDLE;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 6'b000000;
      step_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= bus.opcode;
      if (retire) cnt_q <= cnt_q + 1'b1;
      // Leaving IDLE consumes the latch; otherwise any step seen while stopped is remembered once
      if (state_q == IDLE && state_d == FETCH)
        step_q <= 1'b0;
      else if (bus.step && !bus.run && state_q != HALT)
        step_q <= 1'b1;
    end
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     illegal_q <= 1'b0;
    else if (trap) illegal_q <= 1'b1;
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.s_inc     = s_inc;
  assign bus.s_inm     = s_inm;
  assign bus.we        = we;
  assign bus.wez       = wez;
  assign bus.ALUOp     = alu_op;
  assign bus.pc_en     = pc_en;
  assign bus.ir_en     = ir_en;
  assign bus.busy      = busy;
  assign bus.halted    = halted;
  assign bus.instr_cnt = cnt_q;
endmodule

// File: tb/tb_seq_control_unit.sv
// tb/tb_seq_control_unit.sv - scoreboard bench for seq_control_unit with an emulated IR/PC/zero datapath
module tb_seq_control_unit;
  localparam logic [5:0] HALT_OP = 6'b111111;
  localparam logic [5:0] RSV_OP  = 6'b110000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_control_unit_if #(.CNT_W(16)) bus ();
  seq_control_unit_if #(.CNT_W(2))  bus2 ();

  seq_control_unit #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
  seq_control_unit #(.CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus2.opcode = bus.opcode;
  assign bus2.zero   = bus.zero;
  assign bus2.run    = bus.run;
  assign bus2.step   = bus.step;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         cycles;
    bit         halt;
    logic [2:0] aluop;
    bit         s_inm;
    bit         s_inc;
    bit         wr;
  } exp_t;

  // Instruction-level reference: what one opcode should do, given the zero flag at fetch time
  function automatic exp_t model(input logic [5:0] op, input logic z);
    exp_t e;
    int   v = int'(op);
    e.cycles = 3; e.halt = 0; e.aluop = 3'd0; e.s_inm = 0; e.s_inc = 1; e.wr = 0;
    if (op == HALT_OP) e.halt = 1;
    else if (v < 32) begin
      e.cycles = 4; e.aluop = 3'(v % 8); e.s_inm = (v >= 16); e.wr = 1;
    end
    else if (v == 32) e.s_inc = 0;
    else if (v == 33) e.s_inc = !z;
    else if (v == 34) e.s_inc = z;
    else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
      e.halt = 1;
`endif
    end
    return e;
  endfunction

  function automatic logic [5:0] rand_op();
    int k = $urandom_range(0, 3);
`ifdef SEQ_ILLEGAL_TRAP_EN
    if (k == 3) k = 1;
`endif
    case (k)
      0:       return 6'($urandom_range(0, 15));
      1:       return 6'($urandom_range(16, 31));
      2:       return 6'($urandom_range(32, 34));
      default: return 6'($urandom_range(35, 62));
    endcase
  endfunction

  logic [5:0] prog [64];
  logic [5:0] pc;
  exp_t       exp_q [$];

  // Datapath stand-in: IR, PC and zero flag are registers updated by the sequencer's enables
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= 6'd0;
      bus.opcode <= 6'd0;
      bus.zero   <= 1'b0;
      exp_q.delete();
    end else begin
      if (bus.ir_en) begin
        bus.opcode <= prog[pc];
        exp_q.push_back(model(prog[pc], bus.zero));
      end
      if (bus.pc_en) pc <= bus.s_inc ? pc + 6'd1 : pc + 6'd5;
      if (bus.wez) bus.zero <= 1'($urandom_range(0, 1));
    end
  end

  int   cyc = 0;
  int   start = 0;
  int   retired = 0;
  bit   cnt_chk = 0;
  logic halted_prev = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      retired = 0; cnt_chk = 0; halted_prev = 0;
    end else begin
      if (cnt_chk) begin
        chk("instr_cnt", bus.instr_cnt, retired % 65536);
        chk("instr_cnt_w2", bus2.instr_cnt, retired % 4);
        cnt_chk = 0;
      end
      if (bus.ir_en) start = cyc;
      if (bus.pc_en) begin
        if (exp_q.size() == 0) chk("retire_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("retire_kind_halt", e.halt, 0);
          chk("latency", cyc - start + 1, e.cycles);
          chk("aluop", bus.ALUOp, e.aluop);
          chk("s_inm", bus.s_inm, e.s_inm);
          chk("s_inc", bus.s_inc, e.s_inc);
          chk("we", bus.we, e.wr);
          chk("wez", bus.wez, e.wr);
          retired++;
          cnt_chk = 1;
        end
      end
      if (bus.halted && !halted_prev) begin
        if (exp_q.size() == 0) chk("halt_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("halt_kind", e.halt, 1);
          chk("halt_latency", cyc - start, 2);
        end
      end
      halted_prev = bus.halted;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_step();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outputs"}, {bus.s_inc, bus.s_inm, bus.we, bus.wez, bus.ALUOp, bus.pc_en,
                            bus.ir_en, bus.busy, bus.halted, bus.illegal}, 0);
    chk({tag, "_instr_cnt"}, bus.instr_cnt, 0);
  endtask

  task automatic do_reset();
    bus.run = 1'b0;
    bus.step = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int bound);
    int n = 0;
    while (!bus.halted && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_halt_reached"}, bus.halted, 1);
  endtask

  initial begin
    int r0;
    bus.run = 1'b0;
    bus.step = 1'b0;
    for (int i = 0; i < 64; i++) prog[i] = rand_op();
    repeat (2) tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Random program, free running, then run dropped mid-stream
    bus.run = 1'b1;
    repeat (600 + $urandom_range(0, 7)) tick();
    bus.run = 1'b0;
    repeat (8) tick();
    chk("run_drop_idle", bus.busy, 0);
    chk("run_drop_drained", exp_q.size(), 0);

    // Single step, then a step plus two merged pulses while busy
    r0 = retired;
    pulse_step();
    repeat (8) tick();
    chk("step_one", retired - r0, 1);
    chk("step_idle_busy", bus.busy, 0);
    r0 = retired;
    pulse_step();
    tick();
    chk("step_busy", bus.busy, 1);
    pulse_step();
    tick();
    pulse_step();
    repeat (14) tick();
    chk("step_merged", retired - r0, 2);
    chk("step_merged_idle", bus.busy, 0);

    // Asynchronous reset in the middle of WB
    bus.run = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 64; i++) prog[i] = 6'($urandom_range(0, 31));
    repeat (2) tick();
    reset = 1'b0;
    bus.run = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.we && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("wb_reached", bus.we, 1);
    end
    #1 reset = 1'b1;
    #1 check_all_zero("reset_mid_wb");
    bus.run = 1'b0;
    for (int i = 0; i < 64; i++) prog[i] = 6'($urandom_range(0, 31));
    prog[2] = HALT_OP;
    repeat (2) tick();
    reset = 1'b0;

    // HALT after two ALU instructions, deaf to run/step
    bus.run = 1'b1;
    wait_halted("halt", 40);
    for (int i = 0; i < 20; i++) begin
      bus.run  = 1'($urandom_range(0, 1));
      bus.step = 1'($urandom_range(0, 1));
      tick();
      chk("halt_sticky", bus.halted, 1);
      chk("halt_quiet", {bus.busy, bus.pc_en, bus.ir_en}, 0);
    end
    bus.step = 1'b0;
    chk("halt_instr_cnt", bus.instr_cnt, 2);

`ifdef SEQ_ILLEGAL_TRAP_EN
    for (int i = 0; i < 64; i++) prog[i] = 6'($urandom_range(0, 31));
    prog[1] = RSV_OP;
    do_reset();
    bus.run = 1'b1;
    wait_halted("trap", 40);
    repeat (5) begin
      tick();
      chk("trap_pc_en", bus.pc_en, 0);
    end
    chk("trap_illegal", bus.illegal, 1);
    chk("trap_instr_cnt", bus.instr_cnt, 1);
`else
    // Reserved opcodes as NOPs, stepped five times; the 2-bit counter wraps to 1
    for (int i = 0; i < 64; i++) prog[i] = RSV_OP;
    do_reset();
    repeat (5) begin
      pulse_step();
      repeat (6) tick();
    end
    chk("nop_instr_cnt", bus.instr_cnt, 5);
    chk("nop_wrap_w2", bus2.instr_cnt, 1);
    chk("nop_illegal", bus.illegal, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
